// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan controller: register map, CTRL bits, hex font.
// No logic state; the helper function is purely combinational.
// No flow control; the package only provides types and constants.
package sevenseg_pkg;

    // Register byte offsets
    localparam logic [7:0] OFF_CTRL  = 8'h00;
    localparam logic [7:0] OFF_DATA  = 8'h04;
    localparam logic [7:0] OFF_PRESC = 8'h08;
    localparam logic [7:0] OFF_BLINK = 8'h0C;
    localparam logic [7:0] OFF_RAW0  = 8'h10;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_RAW   = 1;
    localparam int CTRL_BLINK = 2;
    localparam int CTRL_MASK  = 8;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } blink_ph_t;

    // Byte-lane merge of a bus write into the current register value
    function automatic logic [31:0] wb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational, zero cycles.
// No backpressure; output follows input continuously.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/wb_sevenseg_scan.sv
// Wishbone-slave multiplexed seven-segment scanner: N digits, prescaled scan, mask, raw/hex, blink, frame irq.
// Latency: bus ack one cycle after request; o_an/o_seg registered, one cycle after index/register change.
// Backpressure: none; every request is acked the next cycle, so at most one access per two cycles.
module wb_sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int                  N_DIGITS  = 8,
    parameter int                  PRESC_W   = 16,
    parameter logic [PRESC_W-1:0]  PRESC_RST = PRESC_W'(12500),
    parameter int                  BLINK_W   = 8,
    parameter int                  AW        = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [AW-1:0]        i_wb_adr,
    input  logic [31:0]          i_wb_dat,
    input  logic [3:0]           i_wb_sel,
    input  logic                 i_wb_we,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    output logic [31:0]          o_wb_rdt,
    output logic                 o_wb_ack,
    output logic [N_DIGITS-1:0]  o_an,
    output logic [6:0]           o_seg,
    output logic                 o_frame_irq
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // Bus-visible registers
    logic                 r_ack;
    logic [31:0]          r_rdt;
    logic                 r_en;
    logic                 r_raw_mode;
    logic                 r_blink_en;
    logic [N_DIGITS-1:0]  r_mask;
    logic [4*N_DIGITS-1:0] r_data;
    logic [PRESC_W-1:0]   r_presc;
    logic [BLINK_W-1:0]   r_blink;
    logic [6:0]           r_raw [N_DIGITS];

    // Scan / blink state and output registers
    logic [PRESC_W-1:0]   r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [BLINK_W-1:0]   r_fcnt;
    blink_ph_t            r_phase;
    logic [N_DIGITS-1:0]  r_an;
    logic [6:0]           r_seg;
    logic                 r_irq;

    logic [7:0]           w_adr;
    logic [7:0]           w_raw_off;
    logic                 w_raw_hit;
    logic                 w_req;
    logic                 w_wr;
    logic [31:0]          w_rd;
    logic [31:0]          w_wval;
    logic                 w_en_on;
    logic                 w_presc_wr;
    logic                 w_tick;
    logic                 w_last;
    logic                 w_wrap;
    logic                 w_lit;
    logic                 w_dead;
    logic [3:0]           w_nib;
    logic [6:0]           w_hex;
    logic                 w_unused_adr;

    // Byte address with the lane bits cleared; lane bits carry no meaning for 32-bit registers
    assign w_adr        = 8'({i_wb_adr[AW-1:2], 2'b00});
    assign w_unused_adr = ^i_wb_adr[1:0];
    assign w_raw_off    = w_adr - OFF_RAW0;
    assign w_raw_hit    = (w_adr >= OFF_RAW0) && (w_raw_off[7:2] < 6'(N_DIGITS));

    assign w_req      = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_wr       = w_req & i_wb_we;
    assign w_wval     = wb_merge(w_rd, i_wb_dat, i_wb_sel);
    assign w_en_on    = w_wr && (w_adr == OFF_CTRL) && w_wval[CTRL_EN];
    assign w_presc_wr = w_wr && (w_adr == OFF_PRESC);

    // Read mux; unimplemented bits and addresses read as zero
    always_comb begin
        w_rd = '0;
        if (w_adr == OFF_CTRL) begin
            w_rd[CTRL_EN]               = r_en;
            w_rd[CTRL_RAW]              = r_raw_mode;
            w_rd[CTRL_BLINK]            = r_blink_en;
            w_rd[CTRL_MASK +: N_DIGITS] = r_mask;
        end else if (w_adr == OFF_DATA) begin
            w_rd[4*N_DIGITS-1:0] = r_data;
        end else if (w_adr == OFF_PRESC) begin
            w_rd[PRESC_W-1:0] = r_presc;
        end else if (w_adr == OFF_BLINK) begin
            w_rd[BLINK_W-1:0] = r_blink;
        end else if (w_raw_hit) begin
            w_rd[6:0] = r_raw[w_raw_off[2 +: IDX_W]];
        end
    end

    // Bus slave: registered ack/read data and byte-lane register writes on the ack edge
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ack      <= 1'b0;
            r_rdt      <= '0;
            r_en       <= 1'b0;
            r_raw_mode <= 1'b0;
            r_blink_en <= 1'b0;
            r_mask     <= '0;
            r_data     <= '0;
            r_presc    <= PRESC_RST;
            r_blink    <= '0;
            for (int k = 0; k < N_DIGITS; k++) begin
                r_raw[k] <= 7'h7F;
            end
        end else begin
            r_ack <= w_req;
            r_rdt <= (w_req && !i_wb_we) ? w_rd : '0;
            if (w_wr) begin
                if (w_adr == OFF_CTRL) begin
                    r_en       <= w_wval[CTRL_EN];
                    r_raw_mode <= w_wval[CTRL_RAW];
                    r_blink_en <= w_wval[CTRL_BLINK];
                    r_mask     <= w_wval[CTRL_MASK +: N_DIGITS];
                end
                if (w_adr == OFF_DATA)  r_data  <= w_wval[4*N_DIGITS-1:0];
                if (w_adr == OFF_PRESC) r_presc <= w_wval[PRESC_W-1:0];
                if (w_adr == OFF_BLINK) r_blink <= w_wval[BLINK_W-1:0];
                for (int k = 0; k < N_DIGITS; k++) begin
                    if (w_raw_hit && (w_raw_off[7:2] == 6'(k))) r_raw[k] <= w_wval[6:0];
                end
            end
        end
    end

    assign w_tick = r_en & (r_cnt == '0);
    assign w_last = (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_wrap = w_tick & w_last;

    // Prescaler and digit index; enabling preloads the counter so digit 0 gets a full period
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!r_en) begin
            r_idx <= '0;
            r_cnt <= w_en_on ? r_presc : '0;
        end else begin
            if (w_tick) r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_presc_wr)  r_cnt <= w_wval[PRESC_W-1:0];
            else if (w_tick) r_cnt <= r_presc;
            else             r_cnt <= r_cnt - 1'b1;
        end
    end

    // Blink phase FSM: toggles after BLINK completed frames, parked ON when blinking is off
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= PH_ON;
            r_fcnt  <= '0;
        end else if (!r_blink_en || (r_blink == '0)) begin
            r_phase <= PH_ON;
            r_fcnt  <= '0;
        end else if (w_wrap) begin
            if (r_fcnt + 1'b1 == r_blink) begin
                r_fcnt <= '0;
                case (r_phase)
                    PH_ON:   r_phase <= PH_OFF;
                    default: r_phase <= PH_ON;
                endcase
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_nib = r_data[{r_idx, 2'b00} +: 4];

    sevenseg_hex_decode u_hex (
        .i_nib (w_nib),
        .o_seg (w_hex)
    );

    // A one-cycle digit slot (reload 0) has no room for a blank, so dead time needs a nonzero reload
    assign w_lit  = r_en & r_mask[r_idx] & ((r_phase == PH_ON) | ~r_blink_en);
    assign w_dead = w_tick & (r_presc != '0);

    // Output registers: blank on the tick cycle, otherwise drive the current digit if lit
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_an  <= '1;
            r_seg <= 7'h7F;
            r_irq <= 1'b0;
        end else begin
            if (w_lit && !w_dead) begin
                r_an  <= ~(N_DIGITS'(1) << r_idx);
                r_seg <= r_raw_mode ? r_raw[r_idx] : w_hex;
            end else begin
                r_an  <= '1;
                r_seg <= 7'h7F;
            end
            r_irq <= w_wrap;
        end
    end

    assign o_wb_ack    = r_ack;
    assign o_wb_rdt    = r_rdt;
    assign o_an        = r_an;
    assign o_seg       = r_seg;
    assign o_frame_irq = r_irq;

endmodule

// File: tb/tb_wb_sevenseg_scan.sv
// Directed self-checking bench for wb_sevenseg_scan: register access, scan timing, mask, raw, blink, reset.
// Latency: samples outputs on the falling edge, half a cycle after the registering edge.
// Backpressure: bus master waits a bounded number of cycles for ack, then flags a failure.
module tb_wb_sevenseg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [31:0] rdt;
    logic        ack;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    int         lit_cnt [8];
    logic [6:0] seg_seen [8];
    int         ff_cnt, on_cnt, irq_cnt, blank_bad, other_cnt, max_run;
    logic [6:0] exp_hex [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    always #5 clk = ~clk;

    wb_sevenseg_scan #(
        .N_DIGITS (8),
        .PRESC_W  (16),
        .BLINK_W  (8),
        .AW       (6)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb_adr    (adr),
        .i_wb_dat    (wdat),
        .i_wb_sel    (sel),
        .i_wb_we     (we),
        .i_wb_cyc    (cyc),
        .i_wb_stb    (stb),
        .o_wb_rdt    (rdt),
        .o_wb_ack    (ack),
        .o_an        (an),
        .o_seg       (seg),
        .o_frame_irq (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access; returns read data captured in the ack cycle
    task automatic wb(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a[5:0]; wdat = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        r = rdt;
        check("ack_latency", n, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb(1'b1, a, d, s, r);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb(1'b0, a, 32'h0, 4'h0, r);
        check(tag, r, exp);
    endtask

    // Collect display statistics over a window of cycles
    task automatic observe(input int ncyc);
        int  run;
        logic found;
        logic [7:0] pat;
        run = 0; ff_cnt = 0; on_cnt = 0; irq_cnt = 0; blank_bad = 0; other_cnt = 0; max_run = 0;
        for (int k = 0; k < 8; k++) begin
            lit_cnt[k]  = 0;
            seg_seen[k] = 7'h7F;
        end
        repeat (ncyc) begin
            @(negedge clk);
            if (an == 8'hFF) begin
                ff_cnt++;
                run = 0;
                if (seg !== 7'h7F) blank_bad++;
            end else begin
                on_cnt++;
                run++;
                if (run > max_run) max_run = run;
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    pat = ~(8'h01 << k);
                    if (an == pat) begin
                        lit_cnt[k]++;
                        seg_seen[k] = seg;
                        found = 1'b1;
                    end
                end
                if (!found) other_cnt++;
            end
            if (irq) irq_cnt++;
        end
    endtask

    initial begin
        int others;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_ack", ack, 1'b0);
        check("rst_rdt", rdt, 32'h0);
        check("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        rd_chk("rst_ctrl", 8'h00, 32'h0);
        rd_chk("rst_data", 8'h04, 32'h0);
        rd_chk("rst_presc", 8'h08, 32'd12500);
        rd_chk("rst_blink", 8'h0C, 32'h0);
        observe(20);
        check("idle_blank", ff_cnt, 20);
        check("idle_irq", irq_cnt, 0);

        // Hex scan, 4 cycles per digit slot (1 dead + 3 lit), 32-cycle frame
        wr(8'h08, 32'd3, 4'hF);
        rd_chk("presc_rb", 8'h08, 32'd3);
        wr(8'h04, 32'h76543210, 4'hF);
        wr(8'h00, 32'h0000FF01, 4'hF);
        observe(96);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan_lit%0d", k), lit_cnt[k], 9);
            check($sformatf("scan_seg%0d", k), seg_seen[k], exp_hex[k]);
        end
        check("scan_dead", ff_cnt, 24);
        check("scan_irq", irq_cnt, 3);
        check("scan_run", max_run, 3);
        check("scan_blankseg", blank_bad, 0);
        check("scan_other", other_cnt, 0);

        // Mask 0x05: only digits 0 and 2
        wr(8'h00, 32'h00000501, 4'hF);
        observe(96);
        others = other_cnt + lit_cnt[1];
        for (int k = 3; k < 8; k++) others += lit_cnt[k];
        check("mask_lit0", lit_cnt[0], 9);
        check("mask_lit2", lit_cnt[2], 9);
        check("mask_others", others, 0);
        check("mask_blank", ff_cnt, 78);
        check("mask_blankseg", blank_bad, 0);
        check("mask_irq", irq_cnt, 3);

        // Raw mode on digit 3, byte-lane writes
        wr(8'h1C, 32'hFFFFFF2A, 4'b0001);
        rd_chk("raw3_rb", 8'h1C, 32'h2A);
        wr(8'h00, 32'h00000803, 4'hF);
        observe(96);
        check("raw_lit3", lit_cnt[3], 9);
        check("raw_seg3", seg_seen[3], 7'h2A);
        check("raw_blank", ff_cnt, 87);
        wr(8'h04, 32'hAAAAAAAA, 4'b0010);
        rd_chk("data_lane1", 8'h04, 32'h7654AA10);
        @(negedge clk);
        check("rdt_idle", rdt, 32'h0);
        wr(8'h30, 32'hFFFFFFFF, 4'hF);
        rd_chk("unimpl_rd", 8'h30, 32'h0);

        // Blink: BLINK=2, PRESC=0 -> 16 cycles on, 16 off, irq every 8 cycles
        wr(8'h00, 32'hFFFFFFF8, 4'hF);
        rd_chk("ctrl_bits", 8'h00, 32'h0000FF00);
        wr(8'h08, 32'h0, 4'hF);
        wr(8'h0C, 32'd2, 4'hF);
        wr(8'h00, 32'h0000FF05, 4'hF);
        observe(96);
        check("blink_on", on_cnt, 48);
        check("blink_run", max_run, 16);
        check("blink_irq", irq_cnt, 12);
        check("blink_blankseg", blank_bad, 0);

        // Reset mid-frame and mid-bus-cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h00; rst_n = 1'b0;
        @(negedge clk);
        check("mrst_an", an, 8'hFF);
        check("mrst_seg", seg, 7'h7F);
        check("mrst_ack", ack, 1'b0);
        check("mrst_rdt", rdt, 32'h0);
        check("mrst_irq", irq, 1'b0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("mrst_ctrl", 8'h00, 32'h0);
        rd_chk("mrst_presc", 8'h08, 32'd12500);
        rd_chk("mrst_blink", 8'h0C, 32'h0);
        observe(20);
        check("mrst_blank", ff_cnt, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
